dot_product_accumulator: RTL
============================

Name: dot_product_accumulator

Overview:
- Downstream stage of the dot-product multiplier. Consumes the stream of 17-bit signed truncated products and sums VEC_LEN of them into one signed dot-product result.
- Returns each result through a valid/ready output handshake, with saturation and a per-result overflow flag.
- Sits between the multiplier output register and the result write-back.

Parameters:
- PROD_WIDTH, 17: product input width, signed two's complement.
- ACC_WIDTH, 24: accumulator and result width, signed; must be >= PROD_WIDTH.
- VEC_LEN, 16: number of terms per dot product; range 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 5: term counter width.

Ports:
- ap_clk, input, 1: single clock, rising edge.
- ap_rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort of the current accumulation.
- prod_data, input, PROD_WIDTH: signed product term.
- prod_valid, input, 1: prod_data is valid.
- prod_last, input, 1: qualifies the term as the final term of a short vector.
- prod_ready, output, 1: block accepts a term this cycle.
- result_data, output, ACC_WIDTH: signed dot-product sum.
- result_ovf, output, 1: saturation occurred during this result.
- result_valid, output, 1: result_data and result_ovf are valid.
- result_ready, input, 1: downstream accepts the result.
- term_count, output, CNT_WIDTH: terms accepted in the current vector.

Behaviour:
- Reset: ap_rst_n is asynchronous and active-low. While low, the block holds state ACCUM and drives result_data=0, result_ovf=0, result_valid=0, term_count=0, accumulator=0. prod_ready is 1 once ap_rst_n is high.
- States:
  - ACCUM: accepting terms.
  - HOLD: presenting a result.
- prod_ready = (state==ACCUM) && !clear. This is combinational from state and clear.
- Term accept: occurs when prod_valid && prod_ready at the clock edge.
- Sum computation:
  - prod_data is sign-extended to ACC_WIDTH+1 bits and added to the sign-extended accumulator.
  - If the sum exceeds 2^(ACC_WIDTH-1)-1, the accumulator loads the max value and the sticky ovf bit sets.
  - If the sum is below -2^(ACC_WIDTH-1), the accumulator loads the min value and the sticky ovf bit sets.
  - Otherwise the accumulator loads the sum.
  - Later terms keep accumulating from the saturated value.
- On each accept, term_count increments.
- End of vector: an accept is final if term_count==VEC_LEN-1 or prod_last==1 (either condition suffices).
  - On the final accept, the registered result_data takes the new accumulator value, result_ovf takes the sticky ovf including this term's ovf, and result_valid goes to 1.
  - The state moves to HOLD. The accumulator, ovf and term_count clear to 0.
  - Latency: result_valid rises the cycle after the final term is accepted.
- HOLD:
  - result_data and result_ovf stay stable while result_valid=1 and result_ready=0.
  - On result_valid && result_ready: result_valid goes to 0 and the state returns to ACCUM. prod_ready rises the following cycle; there is no same-cycle re-accept.
  - Throughput: VEC_LEN+1 cycles per result with result_ready tied high.
- clear in ACCUM: the accumulator, ovf and term_count go to 0. The state stays ACCUM. No result is produced. A simultaneous prod_valid term is dropped, because prod_ready=0.
- clear in HOLD: ignored. The pending result is preserved until it is taken.
- prod_last when term_count==0: a one-term result, equal to the sign-extended prod_data.
- prod_valid while in HOLD: not accepted. The upstream stage must hold the term.
- Async reset mid-vector or in HOLD: all state is discarded immediately. No partial result is emitted.

Test Plan:
1. Reset, then 16 terms of +1000 back-to-back with result_ready=1 -> result_valid one cycle after the 16th accept, result_data=16000, result_ovf=0, term_count returns to 0.
2. 16 terms of -65536 (the 17-bit min), ACC_WIDTH=24 -> sum -1048576 is in range, so result_data=-1048576 and result_ovf=0. With ACC_WIDTH=20 (min -524288) -> result_data=-524288 and result_ovf=1.
3. 5 terms of +3 with prod_last on the 5th -> result_data=15 and result_ovf=0 after 5 accepts. The next vector then starts with term_count=0.
4. result_ready=0 for 10 cycles after result_valid -> prod_ready=0 and result_data stable throughout. Then result_ready=1 for one cycle -> result_valid=0 and prod_ready=1 the next cycle.
5. Accept 7 terms of +100, then assert clear with prod_valid=1 -> the term is dropped and term_count=0. The next 16 terms of +1 give result_data=16.
6. Drop ap_rst_n asynchronously mid-cycle while in HOLD with result_valid=1 -> result_valid, result_data and term_count are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Sums VEC_LEN (or fewer, via prod_last) signed products with saturation; result registered one cycle after final accept.
// Stalls input (prod_ready=0) while a result is held awaiting result_ready; clear aborts an in-progress vector.
module dot_product_accumulator #(
  parameter int PROD_WIDTH = 17,
  parameter int ACC_WIDTH  = 24,
  parameter int VEC_LEN    = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  clear,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  result_data,
  output logic                  result_ovf,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [CNT_WIDTH-1:0]  term_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_ovf;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ACC_WIDTH-1:0]   r_result;
  logic                   r_result_ovf;
  logic                   r_result_valid;

  logic [ACC_WIDTH:0]     w_acc_ext;
  logic [ACC_WIDTH:0]     w_prod_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_pos_ovf;
  logic                   w_neg_ovf;
  logic [ACC_WIDTH-1:0]   w_acc_next;
  logic                   w_ovf_next;
  logic                   w_accept;
  logic                   w_final;

  // One guard bit above ACC_WIDTH: a mismatch between the top two sum bits means the result left the signed range.
  assign w_acc_ext  = {r_acc[ACC_WIDTH-1], r_acc};
  assign w_prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign w_sum      = w_acc_ext + w_prod_ext;
  assign w_pos_ovf  = !w_sum[ACC_WIDTH] &&  w_sum[ACC_WIDTH-1];
  assign w_neg_ovf  =  w_sum[ACC_WIDTH] && !w_sum[ACC_WIDTH-1];
  assign w_acc_next = w_pos_ovf ? ACC_MAX :
                      w_neg_ovf ? ACC_MIN : w_sum[ACC_WIDTH-1:0];
  assign w_ovf_next = r_ovf || w_pos_ovf || w_neg_ovf;

  assign prod_ready = (r_state == ACCUM) && !clear;
  assign w_accept   = prod_valid && prod_ready;
  assign w_final    = (r_cnt == LAST_IDX) || prod_last;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state        <= ACCUM;
      r_acc          <= '0;
      r_ovf          <= 1'b0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
          end else if (w_accept) begin
            if (w_final) begin
              r_result       <= w_acc_next;
              r_result_ovf   <= w_ovf_next;
              r_result_valid <= 1'b1;
              r_state        <= HOLD;
              r_acc          <= '0;
              r_ovf          <= 1'b0;
              r_cnt          <= '0;
            end else begin
              r_acc <= w_acc_next;
              r_ovf <= w_ovf_next;
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          // clear is deliberately ignored here so a finished result is never lost.
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign result_data  = r_result;
  assign result_ovf   = r_result_ovf;
  assign result_valid = r_result_valid;
  assign term_count   = r_cnt;

endmodule
